// File: rtl/cpu_harness_ctrl.sv
// Control stage that loads a program into the cpu instruction memory, runs the core for a
// configured number of cycles, then reads back data memory and streams it out.
module cpu_harness_ctrl #(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] run_cycles,
    input  logic [10:0] dump_words,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        m_last,
    output logic        cpu_arst_n,
    output logic        cpu_enable,
    output logic [63:0] imem_addr,
    output logic        imem_wen,
    output logic [31:0] imem_wdata,
    output logic [63:0] dmem_addr,
    output logic        dmem_ren,
    input  logic [63:0] dmem_rdata,
    output logic        busy,
    output logic        done,
    output logic        load_err
);

    localparam int WCW = $clog2(IMEM_WORDS) + 1;
    localparam logic [WCW-1:0] WLAST = WCW'(IMEM_WORDS - 1);
    localparam logic [10:0]    DMAX  = 11'(DMEM_WORDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RUN      = 3'd2,
        DUMP_RD  = 3'd3,
        DUMP_OUT = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t         state_r;
    logic [WCW-1:0] wcnt_r;
    logic [10:0]    dcnt_r;
    logic [31:0]    rcnt_r;
    logic [31:0]    run_r;
    logic [10:0]    dump_r;
    logic [10:0]    dump_clamp_s;
    logic [10:0]    dcnt_inc_s;

    // Clamp the requested dump length to the data memory size and precompute the next index.
    always_comb begin
        dump_clamp_s = dump_words;
        if (dump_words > DMAX) begin
            dump_clamp_s = DMAX;
        end else begin
            dump_clamp_s = dump_words;
        end
        dcnt_inc_s = dcnt_r + 11'd1;
    end

    // Sequencer: every output is a register updated alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            wcnt_r     <= '0;
            dcnt_r     <= 11'd0;
            rcnt_r     <= 32'd0;
            run_r      <= 32'd0;
            dump_r     <= 11'd0;
            s_ready    <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= 64'd0;
            m_last     <= 1'b0;
            cpu_arst_n <= 1'b0;
            cpu_enable <= 1'b0;
            imem_addr  <= 64'd0;
            imem_wen   <= 1'b0;
            imem_wdata <= 32'd0;
            dmem_addr  <= 64'd0;
            dmem_ren   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // Memory strobes are single-cycle pulses unless re-armed below.
            imem_wen <= 1'b0;
            dmem_ren <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        run_r      <= run_cycles;
                        dump_r     <= dump_clamp_s;
                        wcnt_r     <= '0;
                        dcnt_r     <= 11'd0;
                        rcnt_r     <= 32'd0;
                        done       <= 1'b0;
                        load_err   <= 1'b0;
                        busy       <= 1'b1;
                        s_ready    <= 1'b1;
                        cpu_arst_n <= 1'b0;
                        cpu_enable <= 1'b0;
                        m_valid    <= 1'b0;
                        m_last     <= 1'b0;
                        state_r    <= LOAD;
                    end else begin
                        state_r <= state_r;
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        imem_wen   <= 1'b1;
                        imem_addr  <= 64'({wcnt_r, 2'b00});
                        imem_wdata <= s_data;
                        wcnt_r     <= wcnt_r + WCW'(1);
                        if (s_last) begin
                            s_ready    <= 1'b0;
                            cpu_arst_n <= 1'b1;
                            cpu_enable <= (run_r != 32'd0);
                            rcnt_r     <= 32'd0;
                            state_r    <= RUN;
                        end else if (wcnt_r == WLAST) begin
                            // Memory full without s_last: abandon the run.
                            s_ready  <= 1'b0;
                            load_err <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state_r  <= DONE;
                        end else begin
                            state_r <= LOAD;
                        end
                    end else begin
                        state_r <= LOAD;
                    end
                end
                RUN: begin
                    if (cpu_enable && (rcnt_r != run_r - 32'd1)) begin
                        rcnt_r <= rcnt_r + 32'd1;
                    end else begin
                        cpu_enable <= 1'b0;
                        dmem_ren   <= (dump_r != 11'd0);
                        dmem_addr  <= 64'd0;
                        state_r    <= DUMP_RD;
                    end
                end
                DUMP_RD: begin
                    // dmem_ren was armed on entry iff another word remains.
                    if (dcnt_r == dump_r) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= DUMP_OUT;
                    end
                end
                DUMP_OUT: begin
                    if (!m_valid) begin
                        m_data  <= dmem_rdata;
                        m_last  <= (dcnt_r == dump_r - 11'd1);
                        m_valid <= 1'b1;
                    end else if (m_ready) begin
                        m_valid   <= 1'b0;
                        m_last    <= 1'b0;
                        dcnt_r    <= dcnt_inc_s;
                        dmem_ren  <= (dcnt_inc_s != dump_r);
                        dmem_addr <= 64'({dcnt_inc_s, 3'b000});
                        state_r   <= DUMP_RD;
                    end else begin
                        state_r <= DUMP_OUT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
